// File: rtl/sound_sequencer.sv
// Note sequencer: steps a writable {phase increment, duration} table on a tick
// and drives phase_inc/gate of the tone oscillator.
//
// state | meaning
// IDLE  | silent, waiting for start
// FETCH | reading entry[idx]; rd_valid marks the cycle the read data is usable
// PLAY  | note sounding; remaining counts ticks down to 1
module sound_sequencer #(
   parameter int NOTES     = 16,
   parameter int INC_W     = 24,
   parameter int DUR_W     = 12,
   parameter int TICK_DIV  = 25000,
   parameter int GAP_TICKS = 20,
   localparam int IDX_W    = $clog2(NOTES)
) (
   input  logic             clk_25mhz,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [INC_W-1:0] wr_inc,
   input  logic [DUR_W-1:0] wr_dur,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   output logic [INC_W-1:0] phase_inc,
   output logic             gate,
   output logic             busy,
   output logic [IDX_W-1:0] note_idx,
   output logic             done
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] GAP     = DUR_W'(GAP_TICKS);

   typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

   state_t                   state, state_n;
   logic [IDX_W-1:0]         idx, idx_n;
   logic                     wrapped, wrapped_n;
   logic                     rd_valid, rd_valid_n;
   logic [DUR_W-1:0]         remaining, remaining_n;
   logic [PRE_W-1:0]         pre, pre_n;
   logic [INC_W-1:0]         phase_n;
   logic [IDX_W-1:0]         note_n;
   logic                     done_n;
   logic [INC_W+DUR_W-1:0]   mem [NOTES];
   logic [INC_W+DUR_W-1:0]   rd_data;
   logic [INC_W-1:0]         rd_inc;
   logic [DUR_W-1:0]         rd_dur;
   logic [IDX_W:0]           idx_inc;

   // Table is never reset; the read port samples idx every cycle, so the
   // data seen in the second FETCH cycle belongs to the current idx.
   always_ff @(posedge clk_25mhz) begin
      if (wr_en) mem[wr_addr] <= {wr_inc, wr_dur};
      rd_data <= mem[idx];
   end

   assign rd_inc  = rd_data[INC_W+DUR_W-1:DUR_W];
   assign rd_dur  = rd_data[DUR_W-1:0];
   assign idx_inc = {1'b0, idx} + (IDX_W+1)'(1);

   assign busy = (state != IDLE);
   assign gate = (state == PLAY) && (phase_inc != '0) && (remaining > GAP);

   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         wrapped   <= 1'b0;
         rd_valid  <= 1'b0;
         remaining <= '0;
         pre       <= '0;
         phase_inc <= '0;
         note_idx  <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         wrapped   <= wrapped_n;
         rd_valid  <= rd_valid_n;
         remaining <= remaining_n;
         pre       <= pre_n;
         phase_inc <= phase_n;
         note_idx  <= note_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      wrapped_n   = wrapped;
      rd_valid_n  = rd_valid;
      remaining_n = remaining;
      pre_n       = pre;
      phase_n     = phase_inc;
      note_n      = note_idx;
      done_n      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_n    = FETCH;
               idx_n      = '0;
               wrapped_n  = 1'b0;
               rd_valid_n = 1'b0;
            end
         end
         FETCH: begin
            if (!rd_valid) begin
               rd_valid_n = 1'b1;
            end else begin
               rd_valid_n = 1'b0;
               if (wrapped || rd_dur == '0) begin
                  // A marker at entry 0 would restart onto itself forever.
                  if (loop && (wrapped || idx != '0)) begin
                     idx_n     = '0;
                     wrapped_n = 1'b0;
                  end else begin
                     state_n = IDLE;
                     phase_n = '0;
                     done_n  = 1'b1;
                  end
               end else begin
                  phase_n     = rd_inc;
                  remaining_n = rd_dur;
                  pre_n       = '0;
                  note_n      = idx;
                  state_n     = PLAY;
               end
            end
         end
         PLAY: begin
            if (pre == PRE_MAX) begin
               pre_n       = '0;
               remaining_n = remaining - DUR_W'(1);
               if (remaining == DUR_W'(1)) begin
                  idx_n      = idx_inc[IDX_W-1:0];
                  wrapped_n  = idx_inc[IDX_W];
                  rd_valid_n = 1'b0;
                  state_n    = FETCH;
               end
            end else begin
               pre_n = pre + PRE_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      if (stop) begin
         state_n = IDLE;
         phase_n = '0;
         done_n  = 1'b0;
      end
   end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: a per-note trace model built from the table
// contents, plus directed stop/reset/write scenarios.
module tb_sound_sequencer;

   localparam int NN  = 4;
   localparam int TD  = 4;
   localparam int GAP = 1;

   logic        clk_25mhz = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_addr = '0;
   logic [23:0] wr_inc = '0;
   logic [11:0] wr_dur = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic [23:0] phase_inc;
   logic        gate;
   logic        busy;
   logic [1:0]  note_idx;
   logic        done;

   int checks = 0;
   int errors = 0;
   int tbl_inc [NN];
   int tbl_dur [NN];
   int m_note = 0;

   typedef struct {int ph; int gt; int bs; int ix; int dn;} exp_t;

   sound_sequencer #(.NOTES(NN), .INC_W(24), .DUR_W(12), .TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
      .clk_25mhz(clk_25mhz), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_inc(wr_inc), .wr_dur(wr_dur), .start(start), .stop(stop), .loop(loop),
      .phase_inc(phase_inc), .gate(gate), .busy(busy), .note_idx(note_idx), .done(done)
   );

   always #5 clk_25mhz = ~clk_25mhz;

   task automatic write_entry(input int a, input int inc, input int dur);
      wr_en = 1'b1; wr_addr = 2'(a); wr_inc = 24'(inc); wr_dur = 12'(dur);
      @(negedge clk_25mhz);
      wr_en = 1'b0;
      tbl_inc[a] = inc;
      tbl_dur[a] = dur;
   endtask

   // Expected trace from start: 2 fetch cycles before each note decision,
   // dur*TD play cycles per note, and a done cycle at the end.
   task automatic run_seq(input string name, input bit loop_val, input int loop_off);
      exp_t q[$];
      int ph, ni, i, lp;
      bit wr;
      ph = 0; ni = m_note; i = 0; wr = 0;
      repeat (2) q.push_back('{ph, 0, 1, ni, 0});
      while (q.size() < 3000) begin
         if (wr || tbl_dur[i] == 0) begin
            lp = ((q.size() - 1) < loop_off) ? int'(loop_val) : 0;
            if (lp != 0 && (wr || i != 0)) begin
               i = 0; wr = 0;
               repeat (2) q.push_back('{ph, 0, 1, ni, 0});
            end else begin
               q.push_back('{0, 0, 0, ni, 1});
               q.push_back('{0, 0, 0, ni, 0});
               break;
            end
         end else begin
            for (int c = 0; c < tbl_dur[i] * TD; c++)
               q.push_back('{tbl_inc[i],
                             int'(tbl_inc[i] != 0 && (tbl_dur[i] - c / TD) > GAP), 1, i, 0});
            ph = tbl_inc[i]; ni = i;
            i++;
            if (i == NN) begin i = 0; wr = 1; end
            repeat (2) q.push_back('{ph, 0, 1, ni, 0});
         end
      end
      m_note = ni;

      start = 1'b1;
      foreach (q[k]) begin
         @(negedge clk_25mhz);
         start = 1'b0;
         checks++;
         if (phase_inc !== 24'(q[k].ph)) begin
            errors++; $display("FAIL %s phase_inc cyc %0d got %0d want %0d", name, k, phase_inc, q[k].ph);
         end
         checks++;
         if (gate !== 1'(q[k].gt)) begin
            errors++; $display("FAIL %s gate cyc %0d got %0b want %0d", name, k, gate, q[k].gt);
         end
         checks++;
         if (busy !== 1'(q[k].bs)) begin
            errors++; $display("FAIL %s busy cyc %0d got %0b want %0d", name, k, busy, q[k].bs);
         end
         checks++;
         if (note_idx !== 2'(q[k].ix)) begin
            errors++; $display("FAIL %s note_idx cyc %0d got %0d want %0d", name, k, note_idx, q[k].ix);
         end
         checks++;
         if (done !== 1'(q[k].dn)) begin
            errors++; $display("FAIL %s done cyc %0d got %0b want %0d", name, k, done, q[k].dn);
         end
         loop = (k < loop_off) ? loop_val : 1'b0;
      end
      loop = 1'b0;
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({phase_inc, gate, busy, done} !== 27'd0) begin
         errors++;
         $display("FAIL %s idle got phase=%0d gate=%0b busy=%0b done=%0b want all 0",
                  name, phase_inc, gate, busy, done);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_25mhz);
      check_idle("reset");
      checks++;
      if (note_idx !== 2'd0) begin
         errors++; $display("FAIL reset note_idx got %0d want 0", note_idx);
      end
      rst = 1'b0;
      m_note = 0;
      @(negedge clk_25mhz);
   endtask

   task automatic test_basic();
      write_entry(0, 100, 3);
      write_entry(1, 200, 2);
      write_entry(2, 0, 0);
      write_entry(3, 77, 1);
      run_seq("basic", 1'b0, 0);
   endtask

   task automatic test_rest_short();
      write_entry(0, 0, 2);
      write_entry(1, 50, 1);
      write_entry(2, 0, 0);
      run_seq("rest_short", 1'b0, 0);
   endtask

   task automatic test_wrap_loop();
      for (int a = 0; a < NN; a++) write_entry(a, $urandom_range(1, 5000), 1);
      run_seq("wrap_loop", 1'b1, 50);
   endtask

   task automatic test_marker0();
      write_entry(0, 123, 0);
      run_seq("marker0", 1'b1, 1000);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < NN; a++)
            write_entry(a, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 100000),
                        $urandom_range(0, 3));
         run_seq("random", 1'($urandom_range(0, 1)), $urandom_range(0, 80));
      end
   endtask

   task automatic test_stop();
      write_entry(0, 100, 3);
      write_entry(1, 200, 2);
      write_entry(2, 0, 0);
      start = 1'b1;
      @(negedge clk_25mhz);
      start = 1'b0;
      repeat (5) @(negedge clk_25mhz);
      start = 1'b1;
      @(negedge clk_25mhz);
      start = 1'b0;
      checks++;
      if (note_idx !== 2'd0 || phase_inc !== 24'd100 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_in_play got idx=%0d phase=%0d busy=%0b want 0/100/1", note_idx, phase_inc, busy);
      end
      stop = 1'b1;
      @(negedge clk_25mhz);
      stop = 1'b0;
      check_idle("stop_mid_note");
      @(negedge clk_25mhz);
      check_idle("stop_settled");
      start = 1'b1; stop = 1'b1;
      @(negedge clk_25mhz);
      start = 1'b0; stop = 1'b0;
      check_idle("start_stop_idle");
      start = 1'b1;
      @(negedge clk_25mhz);
      start = 1'b0;
      repeat (4) @(negedge clk_25mhz);
      start = 1'b1; stop = 1'b1;
      @(negedge clk_25mhz);
      start = 1'b0; stop = 1'b0;
      check_idle("start_stop_play");
      m_note = 0;
   endtask

   task automatic test_write_and_reset();
      int n100;
      write_entry(0, 100, 3);
      write_entry(1, 200, 2);
      write_entry(2, 0, 0);
      loop = 1'b1;
      start = 1'b1;
      @(negedge clk_25mhz);              // cycle 0
      start = 1'b0;
      repeat (4) @(negedge clk_25mhz);   // cycle 4: playing entry 0
      wr_en = 1'b1; wr_addr = 2'd0; wr_inc = 24'd300; wr_dur = 12'd2;
      n100 = 0;
      for (int c = 5; c <= 13; c++) begin
         @(negedge clk_25mhz);
         wr_en = 1'b0;
         if (phase_inc == 24'd100 && note_idx == 2'd0) n100++;
      end
      checks++;
      if (n100 !== 9) begin
         errors++; $display("FAIL write_during_play old note cycles got %0d want 9", n100);
      end
      repeat (16) @(negedge clk_25mhz);  // cycle 29: second pass, new entry 0
      checks++;
      if (phase_inc !== 24'd300 || note_idx !== 2'd0 || gate !== 1'b1) begin
         errors++;
         $display("FAIL write_next_pass got phase=%0d idx=%0d gate=%0b want 300/0/1", phase_inc, note_idx, gate);
      end
      repeat (4) @(negedge clk_25mhz);   // cycle 33: last tick of the new dur=2
      checks++;
      if (phase_inc !== 24'd300 || gate !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL new_dur_gap got phase=%0d gate=%0b busy=%0b want 300/0/1", phase_inc, gate, busy);
      end
      rst = 1'b1;
      @(negedge clk_25mhz);
      rst = 1'b0; loop = 1'b0;
      check_idle("reset_mid_play");
      checks++;
      if (note_idx !== 2'd0) begin
         errors++; $display("FAIL reset_mid_play note_idx got %0d want 0", note_idx);
      end
      m_note = 0;
      tbl_inc[0] = 300; tbl_dur[0] = 2;
   endtask

   task automatic test_back_to_back();
      write_entry(0, 4321, 2);
      write_entry(1, 0, 1);
      write_entry(2, 999, 0);
      run_seq("b2b_a", 1'b0, 0);
      run_seq("b2b_b", 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rest_short();
      test_wrap_loop();
      test_marker0();
      test_stop();
      test_write_and_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Note sequencer that drives the phase-accumulator tone generator feeding the 4-bit audio_l/audio_r DAC path of top_sound.
- Holds a small writable note table. Each entry is a phase increment plus a duration in ticks.
- Steps through the table on a millisecond tick and presents phase_inc/gate to the oscillator.
- Supports start, stop, loop, rests, and an articulation gap at the end of each note.

Parameters:
- NOTES, 16, table depth (power of 2); index width IDX_W = clog2(NOTES).
- INC_W, 24, phase increment width.
- DUR_W, 12, duration width, in ticks.
- TICK_DIV, 25000, clk_25mhz cycles per tick (1 ms at 25 MHz).
- GAP_TICKS, 20, ticks at the end of each note during which gate is low.

Ports:
- clk_25mhz  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  table write strobe
- wr_addr  in  IDX_W  table write address
- wr_inc  in  INC_W  phase increment to store
- wr_dur  in  DUR_W  duration to store
- start  in  1  single-cycle start pulse
- stop  in  1  single-cycle abort pulse
- loop  in  1  level; restart the sequence at its end
- phase_inc  out  INC_W  increment presented to the oscillator
- gate  out  1  oscillator/amplitude enable
- busy  out  1  high whenever not IDLE
- note_idx  out  IDX_W  index of the current entry
- done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset: synchronous, active-high, wins over all inputs. Outputs on reset: phase_inc=0, gate=0, busy=0, note_idx=0, done=0, state=IDLE. Table contents are not cleared.
- Table storage:
  - Write is synchronous: entry[wr_addr] <= {wr_inc, wr_dur} when wr_en.
  - Writes are accepted in any state and take effect when the entry is next fetched.
  - Read is registered, 1-cycle latency. A same-cycle write and read of the same address returns the old data.
- FSM states: IDLE, FETCH, PLAY.
- IDLE:
  - phase_inc=0, gate=0, busy=0.
  - start=1 and stop=0: idx<=0, next state FETCH, busy=1 from the next cycle.
- FETCH:
  - Issue the read of entry[idx]; data is valid the following cycle.
  - If the fetched dur==0 (end marker), or the index wrapped past NOTES-1, the sequence has ended:
    - loop=1 and idx!=0: idx<=0, stay in FETCH.
    - loop=0, or the end marker is at entry 0: go to IDLE, done=1 for exactly one cycle.
  - Otherwise: phase_inc<=inc, remaining<=dur, prescaler<=0, note_idx<=idx, go to PLAY.
- PLAY:
  - Prescaler counts 0..TICK_DIV-1; a tick occurs when prescaler==TICK_DIV-1, and the prescaler then wraps to 0.
  - On each tick, remaining decrements.
  - gate=1 iff inc!=0 and remaining>GAP_TICKS. inc==0 is a rest (gate=0 throughout). If dur<=GAP_TICKS, gate stays 0 for the whole note.
  - On a tick with remaining==1: idx<=idx+1 (modulo NOTES, with wrap flagged), go to FETCH.
  - PLAY lasts exactly dur*TICK_DIV cycles.
  - Between consecutive notes there are 2 cycles (FETCH and read latency) with gate=0 and phase_inc holding the previous value.
- stop: in any state, the next state is IDLE, gate=0, phase_inc=0, no done pulse.
  - stop and start in the same cycle: stop wins.
- start while busy is ignored.
- loop is sampled only at sequence end, so changing it mid-sequence is safe.
- done is never asserted together with busy rising.
- Widths: remaining is DUR_W bits and never underflows, because remaining==1 ends the note. The prescaler is clog2(TICK_DIV) bits.

Test Plan:
(All scenarios use TICK_DIV=4, GAP_TICKS=1, NOTES=4.)
- Basic play: table {inc=100,dur=3},{inc=200,dur=2},{0,0}; start.
  - phase_inc=100 for 12 cycles, gate high for the first 8 of them.
  - Then phase_inc=200 for 8 cycles, gate high for the first 4.
  - Then done pulses once, busy=0, phase_inc=0.
- Rest and short note: entry {inc=0,dur=2} gives gate=0 for 8 cycles with phase_inc=0; entry {inc=50,dur=1} gives gate=0 throughout.
- Full-table wrap with loop=1: all 4 entries have dur=1 → note_idx sequence 0,1,2,3,0,1… with no done. Deassert loop → done after entry 3, then IDLE.
- End marker at entry 0 with loop=1: start → done within 3 cycles, busy=0, no hang.
- stop mid-note, and start+stop in the same cycle: next cycle state is IDLE, gate=0, phase_inc=0, done=0. A start during PLAY does not change note_idx.
- Reset mid-PLAY, plus a write to the current index during PLAY:
  - rst → all outputs 0 next cycle.
  - The write does not alter the note currently playing; the new value is used on the next loop pass.
